// File: rtl/sseg_scan_if.sv
// Display-side bundle for the 4-digit seven-segment scanner: frame capture
// inputs (load, per-digit patterns, dp and blank masks) and the registered
// multiplexed drive outputs.
interface sseg_scan_if;
  logic       load;
  logic [6:0] seg0;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic [3:0] dp_in;
  logic [3:0] blank;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       dp;
  logic       frame;

  // Producer of display content, consumer of the drive pins.
  modport master (
    output load, seg0, seg1, seg2, seg3, dp_in, blank,
    input  an, sseg, dp, frame
  );

  // The scanner itself.
  modport slave (
    input  load, seg0, seg1, seg2, seg3, dp_in, blank,
    output an, sseg, dp, frame
  );
endinterface

// File: rtl/sseg_scan.sv
// Four-digit multiplexed seven-segment scanner. A prescaler walks the digit
// index through DIV-cycle slots; the first DEAD cycles of each slot keep all
// anodes off to avoid ghosting. New content is staged in a shadow image and
// only swapped into the active image at a frame boundary, so one 4-slot scan
// never mixes two images.
module sseg_scan #(
  parameter int DIV  = 50000,
  parameter int DEAD = 16
) (
  input  logic       clk,
  input  logic       rst,
  sseg_scan_if.slave bus
);
  localparam int            CW       = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);

  // One complete display image: patterns (seg[n] for digit n), dp, blank.
  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
    logic [3:0]      blank;
  } img_t;

  localparam img_t DARK = '{seg: {4{7'h7F}}, dp: 4'h0, blank: 4'hF};

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          pending;
  img_t          shadow;
  img_t          active;
  img_t          live;
  logic          boundary;

  logic [3:0]    an_d;
  logic [6:0]    sseg_d;
  logic          dp_d;
  logic [3:0]    an_q;
  logic [6:0]    sseg_q;
  logic          dp_q;
  logic          frame_q;

  assign live     = '{seg:   {bus.seg3, bus.seg2, bus.seg1, bus.seg0},
                      dp:    bus.dp_in,
                      blank: bus.blank};
  assign boundary = (cnt == CNT_MAX) && (idx == 2'd3);

  // Slot prescaler and digit index; idx advances on each slot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Double-buffered image: load stages into shadow (last load wins); the
  // frame boundary promotes shadow, or takes a coincident load directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow  <= DARK;
      active  <= DARK;
      pending <= 1'b0;
    end else if (bus.load) begin
      shadow <= live;
      if (boundary) begin
        active  <= live;
        pending <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (boundary && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  // Next drive value: dark during the guard window or for a blanked digit.
  always_comb begin
    an_d   = 4'hF;
    sseg_d = 7'h7F;
    dp_d   = 1'b1;
    if ((cnt >= CNT_DEAD) && !active.blank[idx]) begin
      an_d   = ~(4'b0001 << idx);
      sseg_d = active.seg[idx];
      dp_d   = ~active.dp[idx];
    end
  end

  // Output registers: one cycle behind cnt/idx/active; frame follows boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q    <= 4'hF;
      sseg_q  <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_d;
      sseg_q  <= sseg_d;
      dp_q    <= dp_d;
      frame_q <= boundary;
    end
  end

  assign bus.an    = an_q;
  assign bus.sseg  = sseg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;
endmodule
